// File: rtl/key_debounce_if.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_if
// Brief    : Raw key pin in, debounced level / strobes / press counter out.
// Revision : 1.0  initial release
// ============================================================================
interface key_debounce_if;
    logic       key_in;
    logic       key_level;
    logic       key_press;
    logic       key_release;
    logic       key_long;
    logic [7:0] press_count;

    modport master (
        output key_in,
        input  key_level, key_press, key_release, key_long, press_count
    );

    modport slave (
        input  key_in,
        output key_level, key_press, key_release, key_long, press_count
    );
endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : Synchronise and debounce a push-button; registered level,
//            press/release/long-press strobes and a wrapping press counter.
// Revision : 1.0  initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input wire            clk,
    input wire            rst,
    key_debounce_if.slave kb
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   c_db_last   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_hold_sat  = HOLD_W'(LONG_CYCLES);

    localparam logic [1:0] c_st_released    = 2'd0;
    localparam logic [1:0] c_st_press_chk   = 2'd1;
    localparam logic [1:0] c_st_held        = 2'd2;
    localparam logic [1:0] c_st_release_chk = 2'd3;

    logic              r_sync1, r_sync2;
    logic [1:0]        r_state;
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_long_done;
    logic              r_level, r_press, r_release, r_long;
    logic [7:0]        r_count;

    logic              w_raw;
    logic [1:0]        w_state_nxt;
    logic [DB_W-1:0]   w_db_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_long_done_nxt;
    logic              w_level_nxt, w_press_nxt, w_release_nxt, w_long_nxt;
    logic [7:0]        w_count_nxt;

    // Synchroniser idles at the released pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= kb.key_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_raw = r_sync2 ^ ACTIVE_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_released;
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
            r_count     <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_db_cnt    <= w_db_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_long_done <= w_long_done_nxt;
            r_level     <= w_level_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_long      <= w_long_nxt;
            r_count     <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_db_nxt        = r_db_cnt;
        w_hold_nxt      = r_hold_cnt;
        w_long_done_nxt = r_long_done;
        w_level_nxt     = r_level;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        w_long_nxt      = 1'b0;
        w_count_nxt     = r_count;

        case (r_state)
            c_st_released: begin
                if (w_raw) begin
                    w_state_nxt = c_st_press_chk;
                    w_db_nxt    = '0;
                end
            end
            c_st_press_chk: begin
                if (!w_raw) begin
                    w_state_nxt = c_st_released;
                end else if (r_db_cnt == c_db_last) begin
                    w_state_nxt     = c_st_held;
                    w_press_nxt     = 1'b1;
                    w_level_nxt     = 1'b1;
                    w_count_nxt     = r_count + 8'd1;
                    w_hold_nxt      = '0;
                    w_long_done_nxt = 1'b0;
                end else begin
                    w_db_nxt = r_db_cnt + 1'b1;
                end
            end
            c_st_held: begin
                if (r_hold_cnt == c_hold_last && !r_long_done) begin
                    w_long_nxt      = 1'b1;
                    w_long_done_nxt = 1'b1;
                end
                // The edge that leaves for the release check does not count as held time.
                if (!w_raw) begin
                    w_state_nxt = c_st_release_chk;
                    w_db_nxt    = '0;
                end else if (r_hold_cnt != c_hold_sat) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            c_st_release_chk: begin
                if (w_raw) begin
                    w_state_nxt = c_st_held;
                    w_db_nxt    = '0;
                end else if (r_db_cnt == c_db_last) begin
                    w_state_nxt     = c_st_released;
                    w_release_nxt   = 1'b1;
                    w_level_nxt     = 1'b0;
                    w_hold_nxt      = '0;
                    w_long_done_nxt = 1'b0;
                end else begin
                    w_db_nxt = r_db_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_released;
            end
        endcase
    end

    assign kb.key_level   = r_level;
    assign kb.key_press   = r_press;
    assign kb.key_release = r_release;
    assign kb.key_long    = r_long;
    assign kb.press_count = r_count;

endmodule
`default_nettype wire

// File: doc/key_debounce.md
Name: key_debounce

Overview:
Input-side companion to the LED drivers. It reads a mechanical push-button on the 50 MHz Cyclone IV board, synchronises it, and debounces it. It produces a clean level, single-cycle press, release and long-press strobes, and a wrapping press counter. Other fabric logic (blinkers, mode selectors) consumes these strobes instead of raw key pins.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles needed to accept a change (20 ms at 50 MHz); legal range ≥ 2.
- LONG_CYCLES, 50_000_000: cycles spent in HELD before key_long fires (1 s at 50 MHz); legal range ≥ 1.
- ACTIVE_LOW, 1: 1 means the pin reads 0 when pressed (board keys have pull-ups); 0 means the pin reads 1 when pressed.

Ports:
- clk  input  1  system clock, 50 MHz crystal.
- rst  input  1  reset; asynchronous assert, active-high; one clock, no other clock domains.
- key_in  input  1  raw, asynchronous button pin.
- key_level  output  1  debounced pressed level; 1 means pressed.
- key_press  output  1  one-cycle strobe on an accepted press.
- key_release  output  1  one-cycle strobe on an accepted release.
- key_long  output  1  one-cycle strobe, at most once per press, when the hold reaches LONG_CYCLES.
- press_count  output  8  count of accepted presses; wraps 255 → 0.

Behaviour:
- Synchroniser: two flops on key_in, reset to the released pin level (ACTIVE_LOW ? 1 : 0). raw = sync2 XOR ACTIVE_LOW, so raw = 1 means pressed.
- Counters:
  - db_cnt: width $clog2(DEBOUNCE_CYCLES).
  - hold_cnt: width $clog2(LONG_CYCLES+1), saturating.
  - long_done flag.
- Reset values: state RELEASED, all counters 0, long_done 0, every output 0.
- All outputs are registered and change only on a clk rising edge (or on rst assertion).
- FSM, 4 states:
  - RELEASED: raw = 1 → PRESS_CHK, db_cnt ← 0.
  - PRESS_CHK:
    - raw = 0 → RELEASED; no strobe (bounce rejected).
    - raw = 1 and db_cnt == DEBOUNCE_CYCLES-1 → HELD. Same edge: key_press ← 1, key_level ← 1, press_count += 1, hold_cnt ← 0, long_done ← 0.
    - Otherwise db_cnt += 1.
  - HELD:
    - hold_cnt += 1 (saturates at LONG_CYCLES).
    - hold_cnt == LONG_CYCLES-1 and long_done == 0 → key_long ← 1, long_done ← 1.
    - raw = 0 → RELEASE_CHK, db_cnt ← 0. hold_cnt does not advance on this edge.
  - RELEASE_CHK:
    - hold_cnt is frozen and key_level stays 1.
    - raw = 1 → HELD, db_cnt ← 0; no strobe, hold_cnt resumes from its frozen value.
    - raw = 0 and db_cnt == DEBOUNCE_CYCLES-1 → RELEASED. Same edge: key_release ← 1, key_level ← 0, hold_cnt ← 0, long_done ← 0.
    - Otherwise db_cnt += 1.
- Latency: let edge k be the first edge at which sync1 samples an active pin.
  - key_press rises at edge k+2+DEBOUNCE_CYCLES, provided the pin stays active throughout.
  - Release latency is symmetric.
- Strobes are high for exactly one cycle and are never asserted together.
- key_long fires after exactly LONG_CYCLES HELD-state cycles, counted from the HELD entry edge. Cycles spent in RELEASE_CHK are excluded. key_long fires at most once per accepted press.
- A release accepted before LONG_CYCLES produces no key_long.
- press_count wraps 255 → 0 without any flag.
- Reset mid-operation: all state clears immediately.
  - If the key is still held when rst deasserts, it is treated as a new press: key_press fires after the normal latency, and press_count goes 0 → 1.

Test Plan (bench parameters DEBOUNCE_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1):
1. rst=1 with key_in=0 held, then release rst → key_press pulses once at edge k+10; key_level=1; press_count=1.
2. Press glitch: key_in low for 5 cycles, high for 3, repeated 4 times → no strobes; key_level stays 0; press_count stays 0.
3. Clean press held 20 cycles, then clean release → exactly one key_press and one key_release, 20 cycles apart; no key_long; key_level high exactly between the two strobes.
4. Press held 100 cycles, with a 3-cycle release bounce injected at HELD cycle 10 → key_long fires exactly once, 32 HELD cycles after entry, excluding the bounce cycles; no extra press or release strobe from the bounce.
5. 256 clean press/release pairs → press_count reads 255 after pair 255 and 0 after pair 256; each pair produces exactly one key_press and one key_release.
6. Assert rst during RELEASE_CHK while a press is in progress → all outputs read 0 asynchronously in that cycle; a new clean press afterwards yields key_press with press_count=1.
